// File: rtl/ws2812b_in_module.sv
// ws2812b_in_module
// Receive side of a WS2812B single-wire link. It samples the data line,
// classifies each high pulse as 0 or 1 by its width, and assembles 24-bit GRB
// words (MSB first, green byte first). A long low time (the reset gap) marks
// the end of a frame.
//
// Ports:
//   clk            system clock (96 MHz nominal)
//   reset          asynchronous, active-high reset
//   ws2812b_data   asynchronous serial input line
//   word           last decoded GRB word
//   word_available word holds an unread value
//   word_read      consumer acknowledge, one-cycle pulse
//   led_index      position of word within its frame (0 = first LED after a gap)
//   frame_end      one-cycle pulse when the reset gap is detected
//   overflow       one-cycle pulse: a completed word was dropped (previous unread)
//   error          one-cycle pulse: glitch, stuck-high line or partial word
//   debug_info     {state[1:0], sync_data, bit_cnt==0}
//
// Handshake (available/read): word_available rises when a word is loaded and
// stays high until word_read is sampled high while it is set; it then clears
// on the next clock. word and led_index do not change while word_available is
// high, except when a new word completes in the same cycle as word_read. In
// that case the new word is loaded and word_available stays high.
module ws2812b_in_module #(
    parameter int CYCLES_MIN       = 10,
    parameter int CYCLES_THRESHOLD = 57,
    parameter int CYCLES_RET       = 4800,
    parameter int IDX_W            = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ws2812b_data,
    output logic [23:0]      word,
    output logic             word_available,
    input  logic             word_read,
    output logic [IDX_W-1:0] led_index,
    output logic             frame_end,
    output logic             overflow,
    output logic             error,
    output logic [3:0]       debug_info
);

    localparam int CNT_W = $clog2(CYCLES_RET + 1);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(CYCLES_MIN);
    localparam logic [CNT_W-1:0] THR_C  = CNT_W'(CYCLES_THRESHOLD);
    localparam logic [CNT_W-1:0] RET_C  = CNT_W'(CYCLES_RET);
    localparam logic [CNT_W-1:0] RET_M1 = CNT_W'(CYCLES_RET - 1);

    typedef enum logic [1:0] {
        ST_WAIT_GAP = 2'd0,
        ST_LOW      = 2'd1,
        ST_HIGH     = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             sync_q1, sync_data, data_q;
    logic             rise, fall, line_edge, reach_ret;
    logic [CNT_W-1:0] dur_cnt;
    logic [22:0]      shift_reg;
    logic [4:0]       bit_cnt;
    logic [IDX_W-1:0] run_idx;
    logic             bit_valid, bit_value, err_evt, gap_evt, clr_bits, clr_idx;
    logic             complete;

    // Two-flop synchronizer plus one stage for edge detection. Both edges see
    // the same latency, so measured pulse widths are exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1   <= 1'b0;
            sync_data <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            sync_q1   <= ws2812b_data;
            sync_data <= sync_q1;
            data_q    <= sync_data;
        end
    end

    assign rise      = sync_data & ~data_q;
    assign fall      = ~sync_data & data_q;
    assign line_edge = rise | fall;

    // dur_cnt holds the number of completed cycles at the current level. The
    // edge cycle itself is the first one, so the counter reloads with 1.
    // It saturates at CYCLES_RET.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dur_cnt <= '0;
        end else if (line_edge) begin
            dur_cnt <= CNT_W'(1);
        end else if (dur_cnt != RET_C) begin
            dur_cnt <= dur_cnt + CNT_W'(1);
        end
    end

    // True only in the single cycle in which the counter steps onto
    // CYCLES_RET. Gap and stuck-high events therefore fire once per episode.
    assign reach_ret = !line_edge && (dur_cnt == RET_M1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_WAIT_GAP;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        bit_valid  = 1'b0;
        bit_value  = 1'b0;
        err_evt    = 1'b0;
        gap_evt    = 1'b0;
        clr_bits   = 1'b0;
        clr_idx    = 1'b0;
        case (state)
            ST_WAIT_GAP: begin
                // A rising edge reloads dur_cnt, which restarts the wait.
                if (reach_ret && !sync_data) state_next = ST_LOW;
            end
            ST_LOW: begin
                if (rise) begin
                    state_next = ST_HIGH;
                end else if (reach_ret) begin
                    gap_evt = 1'b1;
                    clr_idx = 1'b1;
                    if (bit_cnt != 5'd0) begin
                        err_evt  = 1'b1;
                        clr_bits = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_next = ST_LOW;
                    if (dur_cnt < MIN_C) begin
                        err_evt = 1'b1;
                    end else begin
                        bit_valid = 1'b1;
                        bit_value = (dur_cnt > THR_C);
                    end
                end else if (reach_ret) begin
                    err_evt    = 1'b1;
                    clr_bits   = 1'b1;
                    clr_idx    = 1'b1;
                    state_next = ST_WAIT_GAP;
                end
            end
            default: state_next = ST_WAIT_GAP;
        endcase
    end

    assign complete = bit_valid && (bit_cnt == 5'd23);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg      <= '0;
            bit_cnt        <= '0;
            run_idx        <= '0;
            word           <= '0;
            word_available <= 1'b0;
            led_index      <= '0;
            frame_end      <= 1'b0;
            overflow       <= 1'b0;
            error          <= 1'b0;
        end else begin
            frame_end <= gap_evt;
            error     <= err_evt;
            overflow  <= 1'b0;

            if (bit_valid) begin
                shift_reg <= {shift_reg[21:0], bit_value};
                bit_cnt   <= complete ? 5'd0 : bit_cnt + 5'd1;
            end else if (clr_bits) begin
                bit_cnt <= 5'd0;
            end

            // run_idx numbers the next word of the frame. led_index is only
            // updated on a load, so it stays paired with the word it labels.
            if (complete) begin
                run_idx <= run_idx + IDX_W'(1);
            end else if (clr_idx) begin
                run_idx <= '0;
            end

            if (complete) begin
                if (!word_available || word_read) begin
                    word           <= {shift_reg, bit_value};
                    word_available <= 1'b1;
                    led_index      <= run_idx;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (word_read) begin
                word_available <= 1'b0;
            end
        end
    end

    assign debug_info = {state, sync_data, (bit_cnt == 5'd0)};

endmodule

// File: tb/tb_ws2812b_in_module.sv
module tb_ws2812b_in_module;

  localparam int T1H = 77;
  localparam int T0H = 38;
  localparam int PER = 120;
  localparam int GAP = 4810;

  logic        clk = 1'b0;
  logic        reset;
  logic        line;
  logic        auto_rd, man_rd;
  logic        word_read;
  logic [23:0] word;
  logic        word_available;
  logic [7:0]  led_index;
  logic        frame_end, overflow, error;
  logic [3:0]  debug_info;

  assign word_read = auto_rd | man_rd;

  ws2812b_in_module dut (
    .clk            (clk),
    .reset          (reset),
    .ws2812b_data   (line),
    .word           (word),
    .word_available (word_available),
    .word_read      (word_read),
    .led_index      (led_index),
    .frame_end      (frame_end),
    .overflow       (overflow),
    .error          (error),
    .debug_info     (debug_info)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];   // {led_index, word}
  logic [7:0]  exp_idx;
  logic        auto_mode;
  int fe_cnt = 0, fe_cyc = 0, fe_err_cnt = 0;
  int err_cnt = 0, err_cyc = 0, ov_cnt = 0, words_seen = 0;
  int last_fall = 0, rise_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    line = 1'b1;
    repeat (b ? T1H : T0H) @(negedge clk);
    line = 1'b0;
    last_fall = cyc;
    repeat (b ? PER - T1H : PER - T0H) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic send_low(input int n);
    line = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // A word the DUT must load: push expectation, advance running index.
  task automatic send_word(input logic [23:0] w);
    exp_q.push_back({exp_idx, w});
    exp_idx++;
    send_bits(w, 24);
  endtask

  // A word the DUT must drop (previous word unread).
  task automatic send_dropped(input logic [23:0] w);
    exp_idx++;
    send_bits(w, 24);
  endtask

  // ---------------- monitor / consumer ----------------
  logic avail_prev, rd_prev, auto_prev, new_word;
  logic [31:0] e;
  initial begin
    avail_prev = 0; rd_prev = 0; auto_prev = 0; auto_rd = 0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        avail_prev = 0; rd_prev = 0; auto_prev = 0; auto_rd = 0;
      end else begin
        if (frame_end) begin
          fe_cnt++; fe_cyc = cyc;
          if (error) fe_err_cnt++;
        end
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (overflow) ov_cnt++;
        if (auto_prev) check("avail_clear", 32'(word_available), 0);
        new_word = word_available && (!avail_prev || rd_prev);
        if (new_word) begin
          words_seen++;
          check("sb_nonempty", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("word", 32'(word), 32'(e[23:0]));
            check("led_index", 32'(led_index), 32'(e[31:24]));
          end
        end
        auto_rd   = auto_mode && new_word;
        auto_prev = auto_rd;
        rd_prev   = auto_rd | man_rd;
        avail_prev = word_available;
      end
    end
  end

  // ---------------- main sequence ----------------
  int fe0, err0, ov0, ws0, fee0;
  initial begin
    reset = 1'b1; line = 1'b0; man_rd = 1'b0; auto_mode = 1'b1; exp_idx = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_word", 32'(word), 0);
    check("rst_avail", 32'(word_available), 0);
    check("rst_idx", 32'(led_index), 0);
    check("rst_pulses", {29'd0, frame_end, overflow, error}, 0);
    check("rst_debug", 32'(debug_info), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Initial gap leaves WAIT_GAP silently, then one word read at once.
    send_low(GAP);
    check("no_fe_wait_gap", fe_cnt, 0);
    err0 = err_cnt;
    send_word(24'hFF0081);
    send_low(GAP);
    check("t1_no_error", err_cnt, err0);
    check("t1_fe", fe_cnt, 1);

    // Three-word frame, timed frame end, index restart after the gap.
    exp_idx = 0; fe0 = fe_cnt;
    send_word(24'h000001);
    send_word(24'h800000);
    send_word(24'hAAAAAA);
    send_low(GAP);
    check("t2_fe_once", fe_cnt, fe0 + 1);
    check("t2_fe_timing", 32'((fe_cyc - last_fall) >= 4800 && (fe_cyc - last_fall) <= 4804), 1);

    // Overflow: consumer never reads.
    exp_idx = 0; auto_mode = 1'b0; ov0 = ov_cnt;
    send_word(24'h111111);
    send_dropped(24'h222222);
    send_low(10);
    check("t3_word_kept", 32'(word), 32'h111111);
    check("t3_overflow", ov_cnt, ov0 + 1);
    // Read lands on the completion cycle of the 24th bit (3-cycle latency).
    exp_q.push_back({exp_idx, 24'h333333});
    exp_idx++;
    send_bits(24'h333333, 23);
    line = 1'b1;
    repeat (T1H) @(negedge clk);
    line = 1'b0;
    @(negedge clk);
    @(negedge clk);
    man_rd = 1'b1;
    @(negedge clk);
    man_rd = 1'b0;
    send_low(PER - T1H);
    check("t3_no_new_overflow", ov_cnt, ov0 + 1);
    check("t3_avail_kept", 32'(word_available), 1);
    check("t3_word_new", 32'(word), 32'h333333);
    @(negedge clk); man_rd = 1'b1;
    @(negedge clk); man_rd = 1'b0;
    #1;
    check("t3_read_clears", 32'(word_available), 0);
    auto_mode = 1'b1;
    send_low(GAP);

    // Glitch mid-word: error, bit discarded, word still correct.
    exp_idx = 0; err0 = err_cnt;
    exp_q.push_back({exp_idx, 24'hC3A55A});
    exp_idx++;
    send_bits(24'hC3A55A, 12);
    line = 1'b1; repeat (5) @(negedge clk);
    send_low(60);
    send_bits(24'h5A5000 << 0 | 24'h000000, 0);
    for (int i = 11; i >= 0; i--) begin
      logic [23:0] w;
      w = 24'hC3A55A;
      send_bit(w[i]);
    end
    send_low(10);
    check("t4_glitch_err", err_cnt, err0 + 1);

    // Partial word then gap: error together with frame_end, no word.
    err0 = err_cnt; fee0 = fe_err_cnt; ws0 = words_seen; fe0 = fe_cnt;
    send_bits(24'hF0F0F0, 12);
    send_low(GAP);
    check("t4_partial_err", err_cnt, err0 + 1);
    check("t4_fe_err_same", fe_err_cnt, fee0 + 1);
    check("t4_fe", fe_cnt, fe0 + 1);
    check("t4_no_word", words_seen, ws0);

    // Stuck high, then bits before a full gap are ignored.
    err0 = err_cnt; fe0 = fe_cnt; ws0 = words_seen;
    line = 1'b1; rise_cyc = cyc;
    repeat (5000) @(negedge clk);
    send_low(200);
    check("t5_stuck_err", err_cnt, err0 + 1);
    check("t5_stuck_timing", 32'((err_cyc - rise_cyc) >= 4800 && (err_cyc - rise_cyc) <= 4804), 1);
    send_bits(24'hFFFFFF, 4);
    send_low(GAP);
    check("t5_ignored", words_seen, ws0);
    check("t5_no_fe", fe_cnt, fe0);
    check("t5_one_err", err_cnt, err0 + 1);
    exp_idx = 0;
    send_word(24'h5A5A5A);
    send_low(10);

    // Reset mid-word with a word pending.
    auto_mode = 1'b0;
    send_word(24'h0F0F0F);
    send_bits(24'hABCDEF, 12);
    line = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mr_word", 32'(word), 0);
    check("mr_avail", 32'(word_available), 0);
    check("mr_idx", 32'(led_index), 0);
    check("mr_pulses", {29'd0, frame_end, overflow, error}, 0);
    check("mr_debug", 32'(debug_info), 32'h1);
    line = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    auto_mode = 1'b1; exp_idx = 0;
    send_low(GAP);
    send_word(24'h123456);
    send_word(24'hFEDCBA);
    send_low(20);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
